// File: rtl/conv_window_gen.sv
// Sliding FxF convolution window generator over a raster pixel stream, with F-1 line buffers.
// Latency: window_valid and frame_done follow the enabled pixel by one cycle.
// Backpressure: none; enable qualifies input, and all state holds while enable is low.
module conv_window_gen #(
    parameter int bitwidth    = 8,
    parameter int channels    = 1,
    parameter int imageWidth  = 11,
    parameter int imageHeight = 11,
    parameter int filterWidth = 3,
    parameter int stride      = 1
) (
    input  logic                                                    clock,
    input  logic                                                    reset,
    input  logic                                                    enable,
    input  logic [bitwidth*channels-1:0]                            data_in,
    output logic [filterWidth*filterWidth*bitwidth*channels-1:0]    window_out,
    output logic                                                    window_valid,
    output logic                                                    frame_done
);

    localparam int F    = filterWidth;
    localparam int FS   = F * F;
    localparam int PIXW = bitwidth * channels;
    localparam int CW   = (imageWidth  > 1) ? $clog2(imageWidth)  : 1;
    localparam int RW   = (imageHeight > 1) ? $clog2(imageHeight) : 1;
    localparam int PW   = (stride      > 1) ? $clog2(stride)      : 1;

    logic [CW-1:0]   col, col_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [PW-1:0]   col_ph, col_ph_nxt;
    logic [PW-1:0]   row_ph, row_ph_nxt;
    logic            col_last, row_last, qualify;

    // Line buffer j holds one full row; it is addressed by the column counter, so a
    // read-before-write at the same address yields the pixel imageWidth enables ago.
    logic [PIXW-1:0] lb_mem [F-1][imageWidth];
    logic [PIXW-1:0] lb_in  [F-1];
    logic [PIXW-1:0] lb_out [F-1];

    // col_in[wr] feeds the right-hand window column; wr=F-1 is the live pixel.
    logic [PIXW-1:0] col_in  [F];
    logic [PIXW-1:0] win     [FS];
    logic [PIXW-1:0] win_src [FS];

    assign col_last = (col == CW'(imageWidth - 1));
    assign row_last = (row == RW'(imageHeight - 1));
    assign qualify  = (col >= CW'(F - 1)) && (row >= RW'(F - 1)) &&
                      (col_ph == '0) && (row_ph == '0);

    // Next raster position and stride phases; phases restart where the first full window lands.
    always_comb begin
        col_nxt    = col_last ? '0 : col + CW'(1);
        row_nxt    = row_last ? '0 : row + RW'(1);
        col_ph_nxt = '0;
        row_ph_nxt = '0;
        if (!(col_last || (col_nxt == CW'(F - 1))) && (col_ph != PW'(stride - 1)))
            col_ph_nxt = col_ph + PW'(1);
        if (!(row_last || (row_nxt == RW'(F - 1))) && (row_ph != PW'(stride - 1)))
            row_ph_nxt = row_ph + PW'(1);
    end

    // Raster position and stride phase counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (enable) begin
            col    <= col_nxt;
            col_ph <= col_ph_nxt;
            if (col_last) begin
                row    <= row_nxt;
                row_ph <= row_ph_nxt;
            end
        end
    end

    genvar j, k;
    generate
        for (j = 0; j < F - 1; j++) begin : g_lb
            if (j == 0) begin : g_first
                assign lb_in[j] = data_in;
            end else begin : g_chain
                assign lb_in[j] = lb_out[j-1];
            end
            assign lb_out[j]         = lb_mem[j][col];
            assign col_in[F - 2 - j] = lb_out[j];

            // Line buffer storage is never reset; edge suppression hides stale rows.
            always_ff @(posedge clock) begin
                if (enable)
                    lb_mem[j][col] <= lb_in[j];
            end
        end
        assign col_in[F-1] = data_in;

        for (k = 0; k < FS; k++) begin : g_win
            if ((k % F) == F - 1) begin : g_load
                assign win_src[k] = col_in[k / F];
            end else begin : g_shift
                assign win_src[k] = win[k+1];
            end
            assign window_out[k*PIXW +: PIXW] = win[k];
        end
    endgenerate

    // Window array shifts left one column per enabled pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FS; i++)
                win[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < FS; i++)
                win[i] <= win_src[i];
        end
    end

    // One-cycle pulses for a legal window and for the last pixel of the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= enable && qualify;
            frame_done   <= enable && col_last && row_last;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench: three instances (stride 1, stride 2, two channels) share one pixel stream.
// Expected windows come from a 2-D image model and are popped on each window_valid.
// Covers continuous, gappy, mid-frame reset and back-to-back frames.
module tb_conv_window_gen;

    localparam int W = 5;
    localparam int H = 5;
    localparam int F = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   data_in;
    logic [15:0]  data_c;
    logic [71:0]  win_a, win_b;
    logic [143:0] win_c;
    logic         va, vb, vc, fa, fb, fc;

    always #5 clock = ~clock;

    conv_window_gen #(.bitwidth(8), .channels(1), .imageWidth(W), .imageHeight(H),
                      .filterWidth(F), .stride(1)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .window_out(win_a), .window_valid(va), .frame_done(fa));

    conv_window_gen #(.bitwidth(8), .channels(1), .imageWidth(W), .imageHeight(H),
                      .filterWidth(F), .stride(2)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .window_out(win_b), .window_valid(vb), .frame_done(fb));

    conv_window_gen #(.bitwidth(8), .channels(2), .imageWidth(W), .imageHeight(H),
                      .filterWidth(F), .stride(1)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_c),
        .window_out(win_c), .window_valid(vc), .frame_done(fc));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           img [H][W];
    int           cur_r = 0, cur_c = 0;
    logic [71:0]  qa[$], qb[$];
    logic [143:0] qc[$];
    int           base_q[$];
    logic         started = 1'b0, final_chk = 1'b0, done = 1'b0;

    function automatic logic qual(input int r, input int c, input int s);
        return (r >= F-1) && (c >= F-1) && ((r-(F-1)) % s == 0) && ((c-(F-1)) % s == 0);
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < F*F; k++)
            w[k*8 +: 8] = 8'(img[r-F+1+k/F][c-F+1+k%F]);
        return w;
    endfunction

    function automatic logic [143:0] exp_win2(input int r, input int c);
        logic [143:0] w;
        logic [7:0]   p;
        w = '0;
        for (int k = 0; k < F*F; k++) begin
            p = 8'(img[r-F+1+k/F][c-F+1+k%F]);
            w[(2*k)*8 +: 8]   = p;
            w[(2*k+1)*8 +: 8] = p | 8'h80;
        end
        return w;
    endfunction

    // Window literal from the plan: offsets of a 3x3 window in a 5-wide frame, plus a corner pixel.
    function automatic logic [71:0] lit_win(input int base, input int corner);
        int offs [9];
        logic [71:0] w;
        offs = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        w = '0;
        for (int k = 0; k < 9; k++)
            w[k*8 +: 8] = 8'(base + corner + offs[k]);
        return w;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_pixel(input int r, input int c, input int v);
        img[r][c] = v;
        enable    = 1'b1;
        data_in   = 8'(v);
        data_c    = {8'(v) | 8'h80, 8'(v)};
        cur_r     = r;
        cur_c     = c;
        if (qual(r, c, 1)) begin
            qa.push_back(exp_win(r, c));
            qc.push_back(exp_win2(r, c));
        end
        if (qual(r, c, 2))
            qb.push_back(exp_win(r, c));
        @(posedge clock); #1;
    endtask

    task automatic idle();
        enable = 1'b0;
        data_in = 8'hA5;
        data_c  = 16'h5AA5;
        @(posedge clock); #1;
    endtask

    task automatic run_frame(input int base, input int idle_pct);
        base_q.push_back(base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (int'($urandom_range(0, 99)) < idle_pct)
                    idle();
                drive_pixel(r, c, base + 5*r + c);
            end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        data_in = 8'hFF;
        data_c  = 16'hFFFF;
        @(posedge clock); #1;
        reset   = 1'b0;
        enable  = 1'b0;
    endtask

    // ---------------- expectations sampled with the DUT ----------------
    logic en_q, rst_q, exp_va, exp_vb, exp_fd;
    always @(posedge clock) begin
        en_q   <= enable && !reset;
        rst_q  <= reset;
        exp_va <= enable && !reset && qual(cur_r, cur_c, 1);
        exp_vb <= enable && !reset && qual(cur_r, cur_c, 2);
        exp_fd <= enable && !reset && (cur_r == H-1) && (cur_c == W-1);
    end

    // ---------------- monitor / scoreboard ----------------
    int          pulses_a = 0, pulses_b = 0;
    logic [71:0] first_a, last_a;
    logic        have_a = 1'b0;
    int          br_b[$];
    int          bs;

    always @(negedge clock) begin
        if (started) begin
            if (rst_q) begin
                chk("rst_win_a", 160'(win_a), '0);
                chk("rst_win_c", 160'(win_c), '0);
                chk("rst_valid", 160'({va, vb, vc}), '0);
                chk("rst_fdone", 160'({fa, fb, fc}), '0);
                pulses_a = 0;
                pulses_b = 0;
                have_a   = 1'b0;
                br_b.delete();
            end else begin
                chk("a_valid", 160'(va), 160'(exp_va));
                chk("b_valid", 160'(vb), 160'(exp_vb));
                chk("c_valid", 160'(vc), 160'(exp_va));
                chk("a_fdone", 160'(fa), 160'(exp_fd));
                chk("b_fdone", 160'(fb), 160'(exp_fd));
                chk("c_fdone", 160'(fc), 160'(exp_fd));

                if (!en_q && have_a)
                    chk("a_hold", 160'(win_a), 160'(last_a));
                if (en_q && !va)
                    have_a = 1'b0;

                if (va) begin
                    if (qa.size() == 0) chk("a_extra", 160'(1), '0);
                    else begin
                        last_a = qa.pop_front();
                        have_a = 1'b1;
                        chk("a_win", 160'(win_a), 160'(last_a));
                    end
                    if (pulses_a == 0) first_a = win_a;
                    pulses_a++;
                end
                if (vb) begin
                    if (qb.size() == 0) chk("b_extra", 160'(1), '0);
                    else chk("b_win", 160'(win_b), 160'(qb.pop_front()));
                    br_b.push_back(int'(win_b[71:64]));
                    pulses_b++;
                end
                if (vc) begin
                    if (qc.size() == 0) chk("c_extra", 160'(1), '0);
                    else chk("c_win", 160'(win_c), 160'(qc.pop_front()));
                end

                if (fa) begin
                    if (base_q.size() == 0) chk("fd_extra", 160'(1), '0);
                    else begin
                        bs = base_q.pop_front();
                        chk("a_count", 160'(pulses_a), 160'(9));
                        chk("b_count", 160'(pulses_b), 160'(4));
                        chk("a_first", 160'(first_a), 160'(lit_win(bs, 0)));
                        chk("a_lastwin", 160'(win_a), 160'(lit_win(bs, 12)));
                        chk("b_nbr", 160'(br_b.size()), 160'(4));
                        if (br_b.size() == 4) begin
                            chk("b_br0", 160'(br_b[0]), 160'(bs + 12));
                            chk("b_br1", 160'(br_b[1]), 160'(bs + 14));
                            chk("b_br2", 160'(br_b[2]), 160'(bs + 22));
                            chk("b_br3", 160'(br_b[3]), 160'(bs + 24));
                        end
                    end
                    pulses_a = 0;
                    pulses_b = 0;
                    br_b.delete();
                end
            end

            if (final_chk && !done) begin
                chk("qa_left", 160'(qa.size()), '0);
                chk("qb_left", 160'(qb.size()), '0);
                chk("qc_left", 160'(qc.size()), '0);
                chk("frames_left", 160'(base_q.size()), '0);
                done = 1'b1;
            end
        end
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        data_in = '0;
        data_c  = '0;
        @(posedge clock); #1;
        started = 1'b1;
        @(posedge clock); #1;
        reset   = 1'b0;
        repeat (2) idle();

        // continuous frame (stride 1, stride 2, two-lane instances together)
        run_frame(0, 0);
        repeat (3) idle();

        // same frame with random idle cycles
        run_frame(0, 40);
        repeat (3) idle();

        // abandon a partial frame with a reset, then restart and stream back-to-back frames
        for (int p = 0; p < 7; p++)
            drive_pixel(p / W, p % W, 200 + p);
        do_reset();
        idle();
        run_frame(0, 0);
        run_frame(100, 0);

        repeat (4) idle();
        final_chk = 1'b1;
        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
